// File: rtl/exec_stage_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : exec_stage_pkg
// Description : Shared opcodes, FSM state encoding and width defaults for the
//               execute/writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_stage_pkg;

    localparam int C_DATA_W_DEF = 8;
    localparam int C_REG_AW_DEF = 3;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_MOV = 4'h8;
    localparam logic [3:0] OP_LDI = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_MUL = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    function automatic logic op_writes(input logic [3:0] op);
        return ((op >= OP_ADD) && (op <= OP_LDI)) || (op == OP_MUL);
    endfunction

    // Opcodes 0xC-0xF behave as NOP and leave the flags alone.
    function automatic logic op_sets_flags(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MUL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/exec_stage_mul.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : shift_add_mul
// Description : W-iteration sequential shift-add multiplier, one multiplier
//               bit per cycle (LSB first); done pulses in the final iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mul #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(W - 1);

    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           active_q, active_d;
    logic [2*W-1:0] acc_sum;

    // product is valid combinationally in the cycle done is high
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done    = active_q && (cnt_q == C_LAST);
    assign product = acc_sum;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            mcand_d  = {{W{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == C_LAST) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/exec_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : exec_stage
// Description : Multi-cycle execute/writeback stage in front of the 8x8
//               register file; ALU, shift-add MUL and Z/C flags.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_stage
    import exec_stage_pkg::*;
#(
    parameter int DATA_W = C_DATA_W_DEF,
    parameter int REG_AW = C_REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        opcode,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [DATA_W-1:0] imm,
    output logic [REG_AW-1:0] rf_srcA,
    output logic [REG_AW-1:0] rf_srcB,
    input  logic [DATA_W-1:0] rf_dataA,
    input  logic [DATA_W-1:0] rf_dataB,
    output logic              rf_ld,
    output logic [REG_AW-1:0] rf_dest,
    output logic [DATA_W-1:0] rf_dataD,
    output logic              flag_z,
    output logic              flag_c,
    output logic              busy
);
    state_e            state_q, state_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [REG_AW-1:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              wr_q, wr_d;
    logic              flag_z_q, flag_z_d, flag_c_q, flag_c_d;

    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic [DATA_W:0]     sum_w, diff_w;
    logic                mul_start, mul_done;
    logic [2*DATA_W-1:0] mul_product;

    shift_add_mul #(.W(DATA_W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (rf_dataA),
        .b       (rf_dataB),
        .done    (mul_done),
        .product (mul_product)
    );

    assign sum_w  = {1'b0, rf_dataA} + {1'b0, rf_dataB};
    assign diff_w = {1'b0, rf_dataA} - {1'b0, rf_dataB};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (opcode_q)
            OP_ADD: begin alu_res = sum_w[DATA_W-1:0];  alu_c = sum_w[DATA_W];  end
            OP_SUB,
            OP_CMP: begin alu_res = diff_w[DATA_W-1:0]; alu_c = diff_w[DATA_W]; end
            OP_AND: alu_res = rf_dataA & rf_dataB;
            OP_OR:  alu_res = rf_dataA | rf_dataB;
            OP_XOR: alu_res = rf_dataA ^ rf_dataB;
            OP_SHL: begin alu_res = rf_dataA << 1; alu_c = rf_dataA[DATA_W-1]; end
            OP_SHR: begin alu_res = rf_dataA >> 1; alu_c = rf_dataA[0];        end
            OP_MOV: alu_res = rf_dataA;
            OP_LDI: alu_res = imm_q;
            default: begin alu_res = '0; alu_c = 1'b0; end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        imm_d     = imm_q;
        result_d  = result_q;
        wr_d      = wr_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    opcode_d = opcode;
                    rd_d     = rd;
                    rs_d     = rs;
                    rt_d     = rt;
                    imm_d    = imm;
                    wr_d     = op_writes(opcode);
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (opcode_q == OP_MUL) begin
                    mul_start = 1'b1;
                    state_d   = ST_MUL;
                end else begin
                    result_d = alu_res;
                    if (op_sets_flags(opcode_q)) begin
                        flag_z_d = (alu_res == '0);
                        flag_c_d = alu_c;
                    end
                    state_d = ST_WB;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    result_d = mul_product[DATA_W-1:0];
                    flag_z_d = (mul_product[DATA_W-1:0] == '0);
                    flag_c_d = |mul_product[2*DATA_W-1:DATA_W];
                    state_d  = ST_WB;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            opcode_q <= OP_NOP;
            rd_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            imm_q    <= '0;
            result_q <= '0;
            wr_q     <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            rd_q     <= rd_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            imm_q    <= imm_d;
            result_q <= result_d;
            wr_q     <= wr_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign rf_srcA     = rs_q;
    assign rf_srcB     = rt_q;
    assign rf_dest     = rd_q;
    assign rf_dataD    = result_q;
    // Gated by reset so an abort in WB can never commit a write
    assign rf_ld       = (state_q == ST_WB) && wr_q && !reset;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_exec_stage
// Description : Scoreboard bench for exec_stage with a behavioural register
//               file attached to its read/write ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_stage;
    import exec_stage_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] opcode;
    logic [2:0] rd, rs, rt;
    logic [7:0] imm;
    logic [2:0] rf_srcA, rf_srcB, rf_dest;
    logic [7:0] rf_dataA, rf_dataB, rf_dataD;
    logic       rf_ld, flag_z, flag_c, busy;

    always #5 clk = ~clk;

    exec_stage #(.DATA_W(8), .REG_AW(3)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
        .rf_srcA(rf_srcA), .rf_srcB(rf_srcB),
        .rf_dataA(rf_dataA), .rf_dataB(rf_dataB),
        .rf_ld(rf_ld), .rf_dest(rf_dest), .rf_dataD(rf_dataD),
        .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
    );

    logic [7:0] rf [8];
    assign rf_dataA = rf[rf_srcA];
    assign rf_dataB = rf[rf_srcB];
    always @(posedge clk) if (rf_ld) rf[rf_dest] <= rf_dataD;

    typedef struct {
        logic       wr;
        logic [2:0] rd, rs, rt;
        logic [7:0] data;
        logic       z, c;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] gm [8];
    logic       gz, gc;
    int checks = 0, errors = 0;
    int n_issued = 0, n_acc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- output monitor ----------------
    logic       prev_busy = 1'b0;
    int         busy_cnt = 0, ld_cnt = 0;
    logic [2:0] ld_dest;
    logic [7:0] ld_data;
    exp_t       me;

    always @(negedge clk) begin
        if (reset) begin
            check("ld_during_reset", rf_ld, 0);
            sb.delete();
            prev_busy = 1'b0;
            busy_cnt  = 0;
            ld_cnt    = 0;
        end else begin
            if (instr_valid && instr_ready) n_acc++;
            if (rf_ld) begin
                ld_cnt++;
                ld_dest = rf_dest;
                ld_data = rf_dataD;
            end
            if (busy) begin
                busy_cnt++;
                if (sb.size() > 0) begin
                    check("srcA", rf_srcA, sb[0].rs);
                    check("srcB", rf_srcB, sb[0].rt);
                end
            end
            if (prev_busy && !busy) begin
                if (sb.size() == 0) begin
                    check("unexpected_completion", 1, 0);
                end else begin
                    me = sb.pop_front();
                    check("ld_count", ld_cnt, me.wr ? 1 : 0);
                    if (me.wr) begin
                        check("dest", ld_dest, me.rd);
                        check("data", ld_data, me.data);
                    end
                    check("flag_z", flag_z, me.z);
                    check("flag_c", flag_c, me.c);
                    check("latency", busy_cnt, me.lat);
                end
                busy_cnt = 0;
                ld_cnt   = 0;
            end
            prev_busy = busy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s,
                         input logic [2:0] t, input logic [7:0] im, input bit abort,
                         output int waits);
        exp_t        e;
        logic [8:0]  w;
        logic [15:0] p;
        logic [7:0]  a, b, res;
        logic        cf, wr, fl;
        int          n;
        bit          acc;
        a = gm[s]; b = gm[t];
        res = 8'h00; cf = 1'b0; wr = 1'b1; fl = 1'b1;
        e.lat = 2;
        case (op)
            4'h1: begin w = {1'b0, a} + {1'b0, b}; res = w[7:0]; cf = w[8]; end
            4'h2: begin res = a - b; cf = (a < b); end
            4'h3: res = a & b;
            4'h4: res = a | b;
            4'h5: res = a ^ b;
            4'h6: begin res = {a[6:0], 1'b0}; cf = a[7]; end
            4'h7: begin res = {1'b0, a[7:1]}; cf = a[0]; end
            4'h8: res = a;
            4'h9: res = im;
            4'hA: begin res = a - b; cf = (a < b); wr = 1'b0; end
            4'hB: begin p = 16'(a) * 16'(b); res = p[7:0]; cf = (p[15:8] != 8'h00); e.lat = 10; end
            default: begin wr = 1'b0; fl = 1'b0; end
        endcase
        e.wr = wr; e.rd = d; e.rs = s; e.rt = t; e.data = res;
        e.z = fl ? (res == 8'h00) : gz;
        e.c = fl ? cf : gc;
        if (!abort) sb.push_back(e);
        n_issued++;
        instr_valid = 1'b1; opcode = op; rd = d; rs = s; rt = t; imm = im;
        waits = 0; n = 0; acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (instr_ready) acc = 1'b1;
            @(posedge clk); #1;
            if (!acc) waits++;
            n++;
        end
        if (!acc) check("accept_timeout", 0, 1);
        else if (!abort) begin
            if (wr) gm[d] = res;
            gz = e.z; gc = e.c;
        end
    endtask

    task automatic drop_valid();
        instr_valid = 1'b0;
        opcode = 4'h1; rd = 3'd7; rs = 3'd5; rt = 3'd6; imm = 8'hEE;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("drain_timeout", 0, 1);
    endtask

    task automatic run1(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s,
                        input logic [2:0] t, input logic [7:0] im);
        int w;
        issue(op, d, s, t, im, 1'b0, w);
        drop_valid();
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w1, w2, w3;
        for (int i = 0; i < 8; i++) begin
            rf[i] = 8'h00;
            gm[i] = 8'h00;
        end
        gz = 1'b0; gc = 1'b0;
        reset = 1'b1;
        instr_valid = 1'b0; opcode = 4'h0; rd = 3'd0; rs = 3'd0; rt = 3'd0; imm = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ld", rf_ld, 0);
        check("rst_z", flag_z, 0);
        check("rst_c", flag_c, 0);
        check("rst_srcA", rf_srcA, 0);
        check("rst_srcB", rf_srcB, 0);
        check("rst_dest", rf_dest, 0);
        check("rst_dataD", rf_dataD, 0);
        @(posedge clk); #1;

        run1(OP_LDI, 3'd3, 3'd0, 3'd0, 8'h5A);
        run1(OP_LDI, 3'd1, 3'd0, 3'd0, 8'hF0);
        run1(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h20);
        run1(OP_ADD, 3'd4, 3'd1, 3'd2, 8'h00);
        run1(OP_SUB, 3'd5, 3'd2, 3'd1, 8'h00);
        run1(OP_CMP, 3'd0, 3'd1, 3'd1, 8'h00);
        run1(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h13);
        run1(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h11);
        run1(OP_MUL, 3'd6, 3'd1, 3'd2, 8'h00);
        run1(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h0F);
        run1(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h03);
        run1(OP_MUL, 3'd7, 3'd1, 3'd2, 8'h00);
        run1(OP_XOR, 3'd4, 3'd1, 3'd1, 8'h00);

        // back-to-back with valid held high
        issue(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h81, 1'b0, w1);
        issue(OP_SHL, 3'd1, 3'd1, 3'd0, 8'h00, 1'b0, w2);
        issue(OP_ADD, 3'd0, 3'd1, 3'd1, 8'h00, 1'b0, w3);
        drop_valid();
        check("b2b_wait2", w2, 2);
        check("b2b_wait3", w3, 2);
        drain();

        // reset during the 4th MUL cycle
        run1(OP_LDI, 3'd6, 3'd0, 3'd0, 8'h77);
        issue(OP_MUL, 3'd6, 3'd1, 3'd2, 8'h00, 1'b1, w1);
        drop_valid();
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        gz = 1'b0; gc = 1'b0;
        @(negedge clk);
        check("abort_ready", instr_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_z", flag_z, 0);
        check("abort_c", flag_c, 0);
        @(posedge clk); #1;

        // illegal opcode keeps prior flags
        run1(OP_SUB, 3'd3, 3'd1, 3'd2, 8'h00);
        run1(4'hE, 3'd5, 3'd1, 3'd2, 8'h00);

        repeat (2) @(posedge clk);
        #1;
        check("accept_count", n_acc, n_issued);
        for (int i = 0; i < 8; i++) check($sformatf("reg%0d", i), rf[i], gm[i]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_stage.md
Name: exec_stage

Overview:
Multi-cycle execute/writeback stage that sits directly upstream of the 8-entry x 8-bit register file. It accepts one decoded instruction at a time through a valid/ready handshake and reads two operands through the register file's combinational read ports. It computes an ALU or shift-add multiply result, then writes the result back through the file's load port. It also maintains the Z/C flags that the game-logic sequencer uses for branching.

Parameters:
DATA_W, 8, operand/result width (must match register file)
REG_AW, 3, register index width (8 registers)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
instr_valid  in  1  decoded instruction present
instr_ready  out  1  stage can accept an instruction (high only in IDLE)
opcode  in  4  operation, encoding below
rd  in  REG_AW  destination register
rs  in  REG_AW  source A register
rt  in  REG_AW  source B register
imm  in  DATA_W  immediate for LDI
rf_srcA  out  REG_AW  register file read address A
rf_srcB  out  REG_AW  register file read address B
rf_dataA  in  DATA_W  read data A (combinational from file)
rf_dataB  in  DATA_W  read data B
rf_ld  out  1  register file write enable
rf_dest  out  REG_AW  write address
rf_dataD  out  DATA_W  write data
flag_z  out  1  zero flag
flag_c  out  1  carry/borrow flag
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE; flag_z=0, flag_c=0, rf_ld=0, rf_dest=0, rf_dataD=0, rf_srcA=0, rf_srcB=0. instr_ready=1 and busy=0 in the cycle after reset deasserts.
- Reset mid-operation aborts the instruction: no write occurs and the flags clear. rf_ld is never high in a cycle where reset is sampled high.
- Handshake: an instruction is accepted on an edge where instr_valid & instr_ready. Fields opcode/rd/rs/rt/imm are latched at that edge. Inputs are ignored at all other times.
- States: IDLE, EXEC, MUL, WB.
  - IDLE -> EXEC on accept.
  - EXEC -> MUL if opcode=MUL, else -> WB.
  - MUL stays for exactly 8 cycles, then -> WB.
  - WB -> IDLE unconditionally.
- Timing, with accept at edge T:
  - EXEC during cycle T+1: rf_srcA=rs_q, rf_srcB=rt_q. The result and flags are registered at the end of EXEC.
  - WB during T+2: rf_ld=1, rf_dest=rd_q, rf_dataD=result_q.
  - instr_ready is high again at T+3.
  - MUL: EXEC at T+1, MUL at T+2..T+9, WB at T+10, ready at T+11.
- Writeback completes before the next accept, so no forwarding or hazard logic is needed.
- rf_srcA/rf_srcB hold rs_q/rt_q in all non-IDLE states. rf_dest/rf_dataD are don't-care when rf_ld=0 but must be stable within a cycle.
- Opcodes:
  - 0 NOP: no write, flags unchanged.
  - 1 ADD: A+B; C = carry-out.
  - 2 SUB: A-B mod 256; C = borrow (A<B unsigned).
  - 3 AND, 4 OR, 5 XOR: C = 0.
  - 6 SHL: A<<1; C = A[7].
  - 7 SHR (logical): A>>1; C = A[0].
  - 8 MOV: rd=A; C = 0.
  - 9 LDI: rd=imm; C = 0.
  - A CMP: computes A-B for flags only; no write (rf_ld stays 0 in WB).
  - B MUL: 8x8 shift-add into a 16-bit accumulator, one multiplier bit per MUL cycle, LSB first; rd = low byte; C = (high byte != 0).
  - C-F: treated exactly as NOP.
- Z = (8-bit result == 0) for every opcode except NOP.
- NOP/CMP/illegal opcodes still pass through WB; the latency is uniform at 3 cycles.
- Register 0 is an ordinary writable register (no hardwired zero). rd may equal rs/rt: operands are captured in EXEC before the write in WB.
- Flags update at the end of EXEC for single-cycle ops and at the end of the last MUL cycle for MUL.

Decomposition:
- Shared package: opcode localparams (OP_NOP..OP_MUL), state encoding (IDLE/EXEC/MUL/WB), DATA_W/REG_AW defaults.
- One natural sub-module: shift_add_mul. It is an 8-iteration sequential multiplier with start/done, taking a, b and returning a 16-bit product. exec_stage owns the FSM and sequences MUL state around its done pulse.
- ALU remains a combinational case block inside exec_stage.

Test Plan:
- Reset, then LDI rd=3 imm=0x5A -> rf_ld=1 at T+2 with rf_dest=3, rf_dataD=0x5A; Z=0 C=0; instr_ready high at T+3.
- With r1=0xF0 and r2=0x20: ADD rd=4 rs=1 rt=2 -> rf_dataD=0x10, C=1, Z=0. Then SUB rd=5 rs=2 rt=1 -> 0x30, C=1 (borrow). Then CMP rs=1 rt=1 -> rf_ld stays 0, Z=1, C=0, r1 unchanged.
- With r1=0x13 and r2=0x11: MUL rd=6 rs=1 rt=2 -> busy for 10 cycles; rf_ld at T+10 with rf_dataD=0x43 (0x0143 low byte), C=1, Z=0. Also MUL 0x0F*0x03 -> 0x2D, C=0.
- Back-to-back: hold instr_valid high with 3 queued instructions -> instr_ready high only every 3rd cycle; each instruction is accepted exactly once. SHL rd=1 rs=1 with r1=0x81 yields r1=0x02, C=1.
- Reset asserted during the 4th MUL cycle -> no rf_ld pulse; flags=0; IDLE with instr_ready=1 the cycle after reset deasserts; rd is unchanged in the register file.
- Opcode 0xE with valid -> accepted, 3-cycle latency, rf_ld never asserted, flags unchanged from the previous instruction.
